demux5_store: RTL

Sequential counterpart to the switch-driven 5-to-1 3-bit multiplexer: a 1-to-5 3-bit demultiplexer with storage. A debounced pushbutton writes the 3-bit value on SW[2:0] into one of five holding registers (U, V, W, X, Y) chosen by SW[17:15], using the same select encoding as the mux. Stored values drive LEDR in the mux input bit positions. LEDG reads back either the selected register or an auto-scan sequence. The block is a top level on the DE2 board, clocked from the 50 MHz oscillator.

---
 rtl/demux5_store_if.sv | 30 +++
 rtl/demux5_store.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/demux5_store_if.sv
// Board-facing signals of demux5_store: pushbuttons and switches in, LEDs out,
// plus read-only debug taps of the scan-mode state and the debounced button levels.
interface demux5_store_if;
    // No handshake on this bus: KEY and SW are raw asynchronous board levels,
    // LEDR/LEDG are continuously driven levels, and the debug taps are plain state views.
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [17:0] LEDR;
    logic [7:0]  LEDG;
    logic        dbg_scan;
    logic [1:0]  dbg_btn;

    modport master (
        output KEY,
        output SW,
        input  LEDR,
        input  LEDG,
        input  dbg_scan,
        input  dbg_btn
    );

    modport slave (
        input  KEY,
        input  SW,
        output LEDR,
        output LEDG,
        output dbg_scan,
        output dbg_btn
    );
endinterface

// File: rtl/demux5_store.sv
// 1-to-5 3-bit demultiplexer with holding registers: a debounced button writes SW[2:0]
// into the register chosen by SW[17:15]; LEDG reads back the selected register or a scan.
module demux5_store #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCAN_CYCLES     = 25000000
) (
    input logic           CLOCK_50,
    demux5_store_if.slave io
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SC_W = $clog2(SCAN_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

    logic            rst_n;
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [1:0]      deb_q;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    logic            wr_press;
    logic            scan_press;
    logic [2:0]      wr_sel;
    logic [2:0]      regs [5];

    mode_t           mode_q;
    mode_t           mode_d;
    logic [SC_W-1:0] scan_step;
    logic [2:0]      scan_idx;
    logic            scan_on;
    logic [2:0]      rd_sel;
    logic [2:0]      rd_data;

    logic            unused_inputs;

    function automatic logic [2:0] decode_sel(input logic [2:0] sel);
        // S2 dominates, so every 1xx code lands on Y just like the original mux.
        return sel[2] ? 3'd4 : {1'b0, sel[1:0]};
    endfunction

    assign rst_n         = io.KEY[0];
    assign btn_raw       = {io.KEY[2], io.KEY[1]};
    assign unused_inputs = ^{io.KEY[3], io.SW[14:3]};

    // Bit 0 is the write button, bit 1 the scan-toggle button.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            deb   <= 2'b11;
            deb_q <= 2'b11;
            for (int b = 0; b < 2; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] != deb[b]) begin
                    if (db_cnt[b] == DB_LAST) begin
                        deb[b]    <= ~deb[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + DB_W'(1);
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    // One-cycle event on each debounced falling edge; releases are silent.
    assign press      = deb_q & ~deb;
    assign wr_press   = press[0];
    assign scan_press = press[1];
    assign wr_sel     = decode_sel(io.SW[17:15]);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_press) begin
            regs[wr_sel] <= io.SW[2:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (scan_press) begin
            mode_d = (mode_q == MODE_NORMAL) ? MODE_SCAN : MODE_NORMAL;
        end
    end

    // Toggling in either direction restarts the scan from U with a fresh step count.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            scan_step <= '0;
            scan_idx  <= '0;
        end else if (scan_press) begin
            scan_step <= '0;
            scan_idx  <= '0;
        end else if (mode_q == MODE_SCAN) begin
            if (scan_step == SC_LAST) begin
                scan_step <= '0;
                scan_idx  <= (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;
            end else begin
                scan_step <= scan_step + SC_W'(1);
            end
        end
    end

    assign scan_on = (mode_q == MODE_SCAN);
    assign rd_sel  = scan_on ? scan_idx : wr_sel;
    assign rd_data = regs[rd_sel];

    assign io.LEDR     = {scan_on ? scan_idx : 3'b000,
                          regs[0], regs[1], regs[2], regs[3], regs[4]};
    assign io.LEDG     = {scan_on, 4'b0000, rd_data};
    assign io.dbg_scan = scan_on;
    assign io.dbg_btn  = deb;
endmodule
